// File: rtl/dds_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : dds_freq_meter
// Description : Measures the period of a sampled DDS waveform by averaging
//               the clock count over a power-of-two number of rising
//               midscale crossings, with hysteresis and timeout detection.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_freq_meter #(
    parameter int data_width  = 8,
    parameter int count_width = 16,
    parameter int periods     = 4,
    parameter int hyst        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [data_width-1:0]  signal_in,
    output logic [count_width-1:0] period_out,
    output logic                   period_valid,
    input  logic                   period_ready,
    output logic                   overflow
);

    localparam int c_log2    = (periods > 1) ? $clog2(periods) : 0;
    localparam int c_acc_w   = count_width + c_log2;
    localparam int c_tally_w = c_log2 + 1;

    localparam logic [data_width-1:0]  c_mid        = data_width'(1) << (data_width - 1);
    localparam logic [31:0]            c_hi_thr     = 32'((1 << (data_width - 1)) + hyst);
    localparam logic [31:0]            c_lo_thr     = 32'((1 << (data_width - 1)) - hyst);
    localparam logic [c_acc_w-1:0]     c_acc_max    = {c_acc_w{1'b1}};
    localparam logic [count_width-1:0] c_sync_last  = {{(count_width-1){1'b1}}, 1'b0};
    localparam logic [c_tally_w-1:0]   c_tally_last = c_tally_w'(periods - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_SYNC    = 3'd2,
        S_MEASURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                 r_state;
    logic [data_width-1:0]  r_s_reg;
    logic                   r_hi;
    logic [c_acc_w-1:0]     r_acc;
    logic [c_tally_w-1:0]   r_tally;
    logic [count_width-1:0] r_sync_cnt;
    logic [count_width-1:0] r_period;
    logic                   r_valid;
    logic                   r_overflow;

    logic [31:0]            w_s_ext;
    logic                   w_set;
    logic                   w_clr;
    logic                   w_hi_next;
    logic                   w_cross;
    logic [c_acc_w-1:0]     w_acc_inc;
    logic [count_width-1:0] w_avg;

    assign w_s_ext   = 32'(r_s_reg);
    assign w_set     = (w_s_ext >= c_hi_thr);
    assign w_clr     = (w_s_ext <= c_lo_thr);
    assign w_hi_next = w_set ? 1'b1 : (w_clr ? 1'b0 : r_hi);
    assign w_cross   = w_set & ~r_hi;
    assign w_acc_inc = r_acc + 1'b1;
    // Accumulator already counts the crossing cycle, so the shift is the average.
    assign w_avg     = w_acc_inc[c_acc_w-1:c_log2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_s_reg    <= c_mid;
            r_hi       <= 1'b0;
            r_acc      <= '0;
            r_tally    <= '0;
            r_sync_cnt <= '0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_s_reg <= signal_in;
            r_hi    <= w_hi_next;
            if (r_state != S_DONE && !enable) begin
                r_state    <= S_IDLE;
                r_acc      <= '0;
                r_tally    <= '0;
                r_sync_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_ARM;
                    end
                    S_ARM: begin
                        if (!r_hi) begin
                            r_state    <= S_SYNC;
                            r_sync_cnt <= '0;
                        end
                    end
                    S_SYNC: begin
                        if (w_cross) begin
                            r_acc   <= '0;
                            r_tally <= '0;
                            r_state <= S_MEASURE;
                        end else if (r_sync_cnt == c_sync_last) begin
                            r_state    <= S_DONE;
                            r_period   <= '1;
                            r_overflow <= 1'b1;
                            r_valid    <= 1'b1;
                        end else begin
                            r_sync_cnt <= r_sync_cnt + 1'b1;
                        end
                    end
                    S_MEASURE: begin
                        r_acc <= w_acc_inc;
                        if (w_acc_inc == c_acc_max) begin
                            r_state    <= S_DONE;
                            r_period   <= '1;
                            r_overflow <= 1'b1;
                            r_valid    <= 1'b1;
                        end else if (w_cross) begin
                            if (r_tally == c_tally_last) begin
                                r_state    <= S_DONE;
                                r_period   <= w_avg;
                                r_overflow <= 1'b0;
                                r_valid    <= 1'b1;
                            end else begin
                                r_tally <= r_tally + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        // hi is already set here, so SYNC resumes on the next rising edge.
                        if (period_ready) begin
                            r_valid    <= 1'b0;
                            r_sync_cnt <= '0;
                            r_state    <= enable ? S_SYNC : S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign period_out   = r_period;
    assign period_valid = r_valid;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dds_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_freq_meter
// Description : Directed bench for dds_freq_meter driven by a 4-bit phase DDS
//               with a scoreboard of expected period results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_freq_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  signal_in = 8'h80;
    logic [15:0] period_out;
    logic        period_valid;
    logic        period_ready = 1'b1;
    logic        overflow;

    typedef struct packed {
        logic [15:0] period;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // DDS stimulus: mode 0 square, 1 sine, 2 constant
    int         mode = 0;
    logic [3:0] phase = 4'd0;
    logic [3:0] incr = 4'd1;
    logic [7:0] const_val = 8'h80;
    logic [7:0] sine_lut [16] = '{8'd128, 8'd177, 8'd218, 8'd245, 8'd255, 8'd245, 8'd218, 8'd177,
                                  8'd128, 8'd79,  8'd38,  8'd11,  8'd1,   8'd11,  8'd38,  8'd79};

    dds_freq_meter #(
        .data_width (8),
        .count_width(16),
        .periods    (4),
        .hyst       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .signal_in   (signal_in),
        .period_out  (period_out),
        .period_valid(period_valid),
        .period_ready(period_ready),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        phase = phase + incr;
        case (mode)
            0:       signal_in = phase[3] ? 8'h00 : 8'hFF;
            1:       signal_in = sine_lut[phase];
            default: signal_in = const_val;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_result(input string tag, input int budget, output int cycles);
        exp_t e;
        bit   got;
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (period_valid === 1'b1) got = 1'b1;
        end
        check({tag, " valid"}, 32'(got), 32'd1);
        if (sb.size() == 0) begin
            check({tag, " scoreboard"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, " period"}, 32'(period_out), 32'(e.period));
            check({tag, " overflow"}, 32'(overflow), 32'(e.ovf));
        end
    endtask

    task automatic stop_run();
        @(negedge clk);
        enable       = 1'b0;
        period_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic start_run(input int m, input logic [3:0] inc);
        mode   = m;
        incr   = inc;
        @(negedge clk);
        enable = 1'b1;
    endtask

    initial begin
        int  cyc;
        bit  held;
        bit  stray;

        repeat (3) @(negedge clk);
        check("reset period_out", 32'(period_out), 32'd0);
        check("reset valid", 32'(period_valid), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        rst = 1'b1;

        // Square wave, phase increment 1 and 2
        start_run(0, 4'd1);
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{16'd16, 1'b0});
            wait_result($sformatf("sq1_%0d", i), 200, cyc);
        end
        stop_run();
        start_run(0, 4'd2);
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{16'd8, 1'b0});
            wait_result($sformatf("sq2_%0d", i), 200, cyc);
        end
        stop_run();

        // Sine wave with hysteresis
        start_run(1, 4'd1);
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{16'd16, 1'b0});
            wait_result($sformatf("sin1_%0d", i), 200, cyc);
        end
        stop_run();
        start_run(1, 4'd2);
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{16'd8, 1'b0});
            wait_result($sformatf("sin2_%0d", i), 200, cyc);
        end
        stop_run();

        // Backpressure: result must hold while ready is low
        period_ready = 1'b0;
        start_run(0, 4'd1);
        sb.push_back('{16'd16, 1'b0});
        wait_result("bp_first", 200, cyc);
        held = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (period_valid !== 1'b1 || period_out !== 16'd16 || overflow !== 1'b0) held = 1'b0;
        end
        check("bp held", 32'(held), 32'd1);
        period_ready = 1'b1;
        @(negedge clk);
        check("bp valid drop", 32'(period_valid), 32'd0);
        sb.push_back('{16'd16, 1'b0});
        wait_result("bp_next", 200, cyc);
        check("bp next latency", 32'(cyc >= 60 && cyc <= 85), 32'd1);
        stop_run();

        // Asynchronous reset in the middle of a measurement
        start_run(0, 4'd1);
        sb.push_back('{16'd16, 1'b0});
        wait_result("pre_rst", 200, cyc);
        repeat (30) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst period_out", 32'(period_out), 32'd0);
        check("rst valid", 32'(period_valid), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        sb.push_back('{16'd16, 1'b0});
        wait_result("post_rst", 200, cyc);
        check("post_rst latency", 32'(cyc >= 64), 32'd1);
        stop_run();

        // Enable dropped mid-measurement
        start_run(0, 4'd1);
        repeat (40) @(negedge clk);
        enable = 1'b0;
        stray  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (period_valid !== 1'b0) stray = 1'b1;
        end
        check("en_drop no valid", 32'(stray), 32'd0);
        enable = 1'b1;
        sb.push_back('{16'd16, 1'b0});
        wait_result("re_enable", 200, cyc);
        stop_run();

        // Constant midscale input: SYNC timeout
        mode      = 2;
        const_val = 8'h00;
        repeat (5) @(negedge clk);
        const_val = 8'h80;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        sb.push_back('{16'hFFFF, 1'b1});
        wait_result("timeout", 70000, cyc);
        check("timeout latency", 32'(cyc >= 65530 && cyc <= 65545), 32'd1);
        stop_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
